unary_adder_sequencer: RTL and testbench

Controller that runs one unary addition job on a UnaryAdder instance. It accepts two binary operand counts and converts them into thermometer-coded bitstreams with per-input ready strobes. It clears the adder before each job, collects the adder's y/valid stream into binary result counts, and reports completion. It sits between the binary control/CPU side and the unary datapath.

---
 rtl/unary_pkg.sv | 20 ++
 rtl/unary_result_collector.sv | 52 +++++
 rtl/unary_adder_sequencer.sv | 172 +++++++++++++++++
 tb/tb_unary_adder_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/unary_pkg.sv
// Shared definitions for the unary adder sequencer: FSM state encoding and the
// stream-ordering mode constants.
`default_nettype none

package unary_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic MODE_SIMUL = 1'b0;
    localparam logic MODE_ALT   = 1'b1;

endpackage

`default_nettype wire

// File: rtl/unary_result_collector.sv
// Counts the valid/one bits the adder returns in answer to ready strobes,
// saturating at the stream length.
`default_nettype none

module unary_result_collector #(
    parameter int INPUT_WIDTH = 32,
    parameter int COUNT_WIDTH = $clog2(INPUT_WIDTH + 1)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic [1:0]             ready_i,
    input  logic                   valid_i,
    input  logic                   y_i,
    output logic [COUNT_WIDTH-1:0] y_ones_o,
    output logic [COUNT_WIDTH-1:0] y_count_o
);

    localparam logic [COUNT_WIDTH-1:0] MAX_CNT = COUNT_WIDTH'(INPUT_WIDTH);

    logic                   rdy_q;
    logic [COUNT_WIDTH-1:0] ones_q;
    logic [COUNT_WIDTH-1:0] count_q;

    // The adder holds valid between strobes, so only the cycle after a strobe counts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdy_q   <= 1'b0;
            ones_q  <= '0;
            count_q <= '0;
        end else begin
            rdy_q <= |ready_i;
            if (clear_i) begin
                ones_q  <= '0;
                count_q <= '0;
            end else if (rdy_q && valid_i) begin
                if (count_q != MAX_CNT) begin
                    count_q <= count_q + 1'b1;
                end
                if (y_i && (ones_q != MAX_CNT)) begin
                    ones_q <= ones_q + 1'b1;
                end
            end
        end
    end

    assign y_ones_o  = ones_q;
    assign y_count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/unary_adder_sequencer.sv
// Runs one unary addition job: thermometer-codes two binary operands into an
// adder, then reports the collected result counts.
`default_nettype none

module unary_adder_sequencer
    import unary_pkg::*;
#(
    parameter int INPUT_WIDTH = 32,
    parameter int COUNT_WIDTH = $clog2(INPUT_WIDTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   mode,
    input  logic [COUNT_WIDTH-1:0] a_val,
    input  logic [COUNT_WIDTH-1:0] b_val,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] y_ones_o,
    output logic [COUNT_WIDTH-1:0] y_count_o,
    output logic                   u_a,
    output logic                   u_b,
    output logic [1:0]             u_ready,
    output logic                   u_reset_n,
    input  logic                   u_y,
    input  logic                   u_valid
);

    localparam int                     K_W        = COUNT_WIDTH + 1;
    localparam logic [COUNT_WIDTH-1:0] MAX_CNT    = COUNT_WIDTH'(INPUT_WIDTH);
    localparam logic [K_W-1:0]         LAST_SIMUL = K_W'(INPUT_WIDTH - 1);
    localparam logic [K_W-1:0]         LAST_ALT   = K_W'(2 * INPUT_WIDTH - 1);

    state_t                 state_q, state_d;
    logic [K_W-1:0]         k_q, k_d;
    logic [COUNT_WIDTH-1:0] a_lat_q, a_lat_d;
    logic [COUNT_WIDTH-1:0] b_lat_q, b_lat_d;
    logic                   mode_q, mode_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   u_a_q, u_a_d;
    logic                   u_b_q, u_b_d;
    logic [1:0]             u_ready_q, u_ready_d;
    logic                   u_reset_n_q, u_reset_n_d;
    logic                   accept;
    logic                   abort_job;
    logic [K_W-1:0]         last_k;

    function automatic logic [COUNT_WIDTH-1:0] clamp_cnt(input logic [COUNT_WIDTH-1:0] v);
        return (v > MAX_CNT) ? MAX_CNT : v;
    endfunction

    assign last_k = (mode_q == MODE_ALT) ? LAST_ALT : LAST_SIMUL;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        a_lat_d   = a_lat_q;
        b_lat_d   = b_lat_q;
        mode_d    = mode_q;
        accept    = 1'b0;
        abort_job = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    accept  = 1'b1;
                    a_lat_d = clamp_cnt(a_val);
                    b_lat_d = clamp_cnt(b_val);
                    mode_d  = mode;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                k_d     = '0;
                state_d = RUN;
            end
            RUN: begin
                if (k_q == last_k) begin
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if ((state_q != IDLE) && abort) begin
            abort_job = 1'b1;
            state_d   = IDLE;
        end
    end

    // Outputs are decoded from next-state values so they appear registered
    // in the same cycle the state does.
    always_comb begin
        u_ready_d = 2'b00;
        u_a_d     = 1'b0;
        u_b_d     = 1'b0;
        if (state_d == RUN) begin
            if (mode_d == MODE_SIMUL) begin
                u_ready_d = 2'b11;
                u_a_d     = (k_d < {1'b0, a_lat_d});
                u_b_d     = (k_d < {1'b0, b_lat_d});
            end else if (!k_d[0]) begin
                u_ready_d = 2'b01;
                u_a_d     = ((k_d >> 1) < {1'b0, a_lat_d});
            end else begin
                u_ready_d = 2'b10;
                u_b_d     = ((k_d >> 1) < {1'b0, b_lat_d});
            end
        end
        u_reset_n_d = !((state_d == CLEAR) || abort_job);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            a_lat_q     <= '0;
            b_lat_q     <= '0;
            mode_q      <= MODE_SIMUL;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            u_a_q       <= 1'b0;
            u_b_q       <= 1'b0;
            u_ready_q   <= 2'b00;
            u_reset_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            a_lat_q     <= a_lat_d;
            b_lat_q     <= b_lat_d;
            mode_q      <= mode_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            u_a_q       <= u_a_d;
            u_b_q       <= u_b_d;
            u_ready_q   <= u_ready_d;
            u_reset_n_q <= u_reset_n_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign u_a       = u_a_q;
    assign u_b       = u_b_q;
    assign u_ready   = u_ready_q;
    assign u_reset_n = u_reset_n_q;

    unary_result_collector #(
        .INPUT_WIDTH (INPUT_WIDTH),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_collector (
        .clk_i     (clk),
        .rst_ni    (reset),
        .clear_i   (accept),
        .ready_i   (u_ready_q),
        .valid_i   (u_valid),
        .y_i       (u_y),
        .y_ones_o  (y_ones_o),
        .y_count_o (y_count_o)
    );

endmodule

`default_nettype wire

// File: tb/tb_unary_adder_sequencer.sv
// Scoreboard bench for unary_adder_sequencer driving a behavioural adder
// (y = OR of strobed inputs, valid held between strobes) or a constant stub.
`default_nettype none

module tb_unary_adder_sequencer;

    localparam int IW = 32;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          mode = 1'b0;
    logic [CW-1:0] a_val = '0;
    logic [CW-1:0] b_val = '0;
    logic          busy, done, u_a, u_b, u_reset_n, u_y, u_valid;
    logic [CW-1:0] y_ones_o, y_count_o;
    logic [1:0]    u_ready;

    logic          const_mode = 1'b0;
    logic          m_valid, m_y;

    unary_adder_sequencer #(.INPUT_WIDTH(IW), .COUNT_WIDTH(CW)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .start     (start),
        .abort     (abort),
        .mode      (mode),
        .a_val     (a_val),
        .b_val     (b_val),
        .busy      (busy),
        .done      (done),
        .y_ones_o  (y_ones_o),
        .y_count_o (y_count_o),
        .u_a       (u_a),
        .u_b       (u_b),
        .u_ready   (u_ready),
        .u_reset_n (u_reset_n),
        .u_y       (u_y),
        .u_valid   (u_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge u_reset_n) begin
        if (!u_reset_n) begin
            m_valid <= 1'b0;
            m_y     <= 1'b0;
        end else if (u_ready != 2'b00) begin
            m_valid <= 1'b1;
            m_y     <= (u_ready[0] & u_a) | (u_ready[1] & u_b);
        end
    end
    assign u_valid = const_mode ? 1'b1 : m_valid;
    assign u_y     = const_mode ? 1'b1 : m_y;

    typedef struct {
        int lat; int ahi; int bhi; int r11; int r01; int r10; int cnt; int ones;
    } exp_t;
    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: per-job activity counters, compared against the scoreboard on done
    int busy_cyc = 0, ahi = 0, bhi = 0, r11 = 0, r01 = 0, r10 = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) begin
                busy_cyc++;
                if (u_a) ahi++;
                if (u_b) bhi++;
                if (u_ready == 2'b11) r11++;
                if (u_ready == 2'b01) r01++;
                if (u_ready == 2'b10) r10++;
            end
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("latency", busy_cyc, e.lat);
                    check("u_a_high_cycles", ahi, e.ahi);
                    check("u_b_high_cycles", bhi, e.bhi);
                    check("ready11_cycles", r11, e.r11);
                    check("ready01_cycles", r01, e.r01);
                    check("ready10_cycles", r10, e.r10);
                    check("y_count", int'(y_count_o), e.cnt);
                    check("y_ones", int'(y_ones_o), e.ones);
                end
            end
            if (!busy) begin
                busy_cyc = 0; ahi = 0; bhi = 0; r11 = 0; r01 = 0; r10 = 0;
            end
        end
    end

    task automatic push(input int lat, ah, bh, q11, q01, q10, cnt, ones);
        exp_t e;
        e.lat = lat; e.ahi = ah; e.bhi = bh; e.r11 = q11; e.r01 = q01; e.r10 = q10;
        e.cnt = cnt; e.ones = ones;
        sb.push_back(e);
    endtask

    task automatic start_job(input logic m, input int a, input int b);
        @(negedge clk);
        mode  = m;
        a_val = CW'(a);
        b_val = CW'(b);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(busy), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #7;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_y_count", int'(y_count_o), 0);
        check("rst_y_ones", int'(y_ones_o), 0);
        check("rst_u_ready", int'(u_ready), 0);
        check("rst_u_ab", int'({u_a, u_b}), 0);
        check("rst_u_reset_n", int'(u_reset_n), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_u_reset_n", int'(u_reset_n), 1);

        push(35, 32, 32, 32, 0, 0, 32, 32);
        start_job(1'b0, 32, 32);
        wait_idle("timeout_simul_full");

        push(67, 3, 1, 0, 32, 32, 32, 4);
        start_job(1'b1, 3, 1);
        wait_idle("timeout_alt");

        push(35, 5, 2, 32, 0, 0, 32, 5);
        start_job(1'b0, 5, 2);
        wait_idle("timeout_simul_5_2");

        const_mode = 1'b1;
        push(35, 0, 0, 32, 0, 0, 32, 32);
        start_job(1'b0, 0, 0);
        wait_idle("timeout_const_stub");
        const_mode = 1'b0;

        // Abort at RUN k=10 (cycle 12 after the start edge)
        start_job(1'b0, 10, 10);
        repeat (11) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_u_reset_n", int'(u_reset_n), 0);
        check("abort_u_ready", int'(u_ready), 0);
        check("abort_done", int'(done), 0);
        check("abort_partial_count", int'(y_count_o), 10);
        @(negedge clk);
        check("abort_after_u_reset_n", int'(u_reset_n), 1);
        repeat (3) @(negedge clk);

        push(35, 32, 0, 32, 0, 0, 32, 32);
        start_job(1'b0, 32, 0);
        wait_idle("timeout_after_abort");

        // A start pulse during RUN must not queue another job
        push(35, 20, 0, 32, 0, 0, 32, 20);
        start_job(1'b0, 20, 0);
        repeat (5) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("timeout_midstart");
        repeat (3) @(negedge clk);
        check("midstart_not_queued", int'(busy), 0);

        push(35, 32, 0, 32, 0, 0, 32, 32);
        start_job(1'b0, 40, 0);
        wait_idle("timeout_clamp");

        // Asynchronous reset in the middle of RUN
        start_job(1'b0, 20, 20);
        repeat (6) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_u_ready", int'(u_ready), 0);
        check("arst_u_a", int'(u_a), 0);
        check("arst_u_reset_n", int'(u_reset_n), 0);
        check("arst_y_count", int'(y_count_o), 0);
        @(negedge clk);
        check("arst_held_u_reset_n", int'(u_reset_n), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_release_busy", int'(busy), 0);
        check("arst_release_u_reset_n", int'(u_reset_n), 1);

        push(35, 7, 3, 32, 0, 0, 32, 7);
        start_job(1'b0, 7, 3);
        wait_idle("timeout_final");

        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
